fixed_p_scaling_shifter: RTL and testbench

- Pipelined, parametrised scaling-shift unit for the lane's fixed-point datapath.
- Executes VSSRL, VSSRA, VNCLIPU and VNCLIP on a packed DataWidth word of elements, including fixed-point rounding.
- Also performs narrowing saturation and keeps a sticky vxsat accumulator.
- Sits between the lane operand queues and the VALU result path, with valid/ready on both sides.

---
 rtl/fixed_p_scaling_shifter_if.sv | 33 +++
 rtl/fixed_p_scaling_shifter.sv | 228 ++++++++++++++++++++++
 tb/tb_fixed_p_scaling_shifter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_p_scaling_shifter_if.sv
// Operand/result handshake bundle for the fixed-point scaling shifter.
// The DUT side is the slave modport; the producer/consumer side is the master.
interface fixed_p_scaling_shifter_if #(
   parameter int DataWidth = 64
);
   logic                   valid_i;
   logic                   ready_o;
   logic [1:0]             op_i;
   logic [1:0]             vew_i;
   logic [1:0]             vxrm_i;
   logic [DataWidth-1:0]   operand_a_i;
   logic [DataWidth-1:0]   operand_b_i;
   logic                   valid_o;
   logic                   ready_i;
   logic [DataWidth-1:0]   result_o;
   logic [DataWidth/8-1:0] sat_o;
   logic                   vxsat_o;
   logic                   vxsat_clr_i;

   modport slave (
      input  valid_i, op_i, vew_i, vxrm_i,
      input  operand_a_i, operand_b_i,
      input  ready_i, vxsat_clr_i,
      output ready_o, valid_o, result_o, sat_o, vxsat_o
   );

   modport master (
      output valid_i, op_i, vew_i, vxrm_i,
      output operand_a_i, operand_b_i,
      output ready_i, vxsat_clr_i,
      input  ready_o, valid_o, result_o, sat_o, vxsat_o
   );
endinterface

// File: rtl/fixed_p_scaling_shifter.sv
// Pipelined VSSRL/VSSRA/VNCLIPU/VNCLIP unit with fixed-point rounding,
// narrowing saturation and a sticky vxsat flag.
module fixed_p_scaling_shifter #(
   parameter int DataWidth = 64,
   parameter int NumStages = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   fixed_p_scaling_shifter_if.slave bus
);
   localparam int NB = DataWidth / 8;

   // Returns {sat, result}; src holds one element zero-extended to 64 bits.
   function automatic logic [64:0] f_elem(
      input logic [63:0] src,
      input logic [6:0]  sew,
      input logic [5:0]  d,
      input logic [1:0]  op,
      input logic [1:0]  rm
   );
      logic [63:0]        mask;
      logic [63:0]        s;
      logic [63:0]        lo1;
      logic [63:0]        lo0;
      logic [5:0]         top;
      logic [5:0]         h;
      logic signed [65:0] ext;
      logic signed [65:0] v;
      logic signed [65:0] sum;
      logic signed [65:0] hi;
      logic signed [65:0] lo;
      logic signed [65:0] clmp;
      logic               bd1;
      logic               bd;
      logic               r;
      logic               sat;

      mask = (sew == 7'd64) ? '1 : ((64'd1 << sew) - 64'd1);
      s    = src & mask;
      top  = 6'(sew - 7'd1);
      ext  = {2'b00, s};
      if (op[0] && s[top]) begin
         ext = ext | ~{2'b00, mask};
      end
      v   = ext >>> d;
      bd1 = (d != 6'd0) && s[6'(d - 6'd1)];
      bd  = s[d];
      lo1 = (d > 6'd1) ? (s & ((64'd1 << (d - 6'd1)) - 64'd1)) : 64'd0;
      lo0 = s & ((64'd1 << d) - 64'd1);
      unique case (rm)
         2'b00:   r = bd1;
         2'b01:   r = bd1 & (bd | (lo1 != 64'd0));
         2'b10:   r = 1'b0;
         default: r = ~bd & (lo0 != 64'd0);
      endcase
      sum = v + {65'd0, r};

      h = 6'(sew >> 1);
      if (op[0]) begin
         hi = (66'sd1 <<< (h - 6'd1)) - 66'sd1;
         lo = -(66'sd1 <<< (h - 6'd1));
      end else begin
         hi = (66'sd1 <<< h) - 66'sd1;
         lo = '0;
      end
      sat  = 1'b0;
      clmp = sum;
      if (sum > hi) begin
         clmp = hi;
         sat  = 1'b1;
      end else if (sum < lo) begin
         clmp = lo;
         sat  = 1'b1;
      end

      if (op[1]) begin
         return {sat, clmp[63:0] & ((64'd1 << h) - 64'd1)};
      end
      return {1'b0, sum[63:0] & mask};
   endfunction

   function automatic logic [NB+DataWidth-1:0] f_word(
      input logic [1:0]           op,
      input logic [1:0]           vew,
      input logic [1:0]           rm,
      input logic [DataWidth-1:0] a,
      input logic [DataWidth-1:0] b
   );
      logic [DataWidth-1:0] res;
      logic [NB-1:0]        sat;
      logic [64:0]          e;

      res = '0;
      sat = '0;
      e   = '0;
      unique case (vew)
         2'b00: begin
            // Narrowing from bytes has no destination width: leave zero.
            if (!op[1]) begin
               for (int i = 0; i < NB; i++) begin
                  e = f_elem({56'd0, b[i*8 +: 8]}, 7'd8,
                             {3'd0, a[i*8 +: 3]}, op, rm);
                  res[i*8 +: 8] = e[7:0];
               end
            end
         end
         2'b01: begin
            for (int i = 0; i < NB/2; i++) begin
               e = f_elem({48'd0, b[i*16 +: 16]}, 7'd16,
                          {2'd0, a[i*16 +: 4]}, op, rm);
               res[i*16 +: 16] = e[15:0];
               sat[i*2 +: 2]   = {2{e[64]}};
            end
         end
         2'b10: begin
            for (int i = 0; i < NB/4; i++) begin
               e = f_elem({32'd0, b[i*32 +: 32]}, 7'd32,
                          {1'd0, a[i*32 +: 5]}, op, rm);
               res[i*32 +: 32] = e[31:0];
               sat[i*4 +: 4]   = {4{e[64]}};
            end
         end
         default: begin
            for (int i = 0; i < NB/8; i++) begin
               e = f_elem(b[i*64 +: 64], 7'd64,
                          a[i*64 +: 6], op, rm);
               res[i*64 +: 64] = e[63:0];
               sat[i*8 +: 8]   = {8{e[64]}};
            end
         end
      endcase
      return {sat, res};
   endfunction

   logic                   r_vl;
   logic                   r_vxsat;
   logic [DataWidth-1:0]   r_res;
   logic [NB-1:0]          r_sat;
   logic                   w_last_rdy;
   logic                   w_ready;
   logic                   w_in_v;
   logic [1:0]             w_op;
   logic [1:0]             w_vew;
   logic [1:0]             w_rm;
   logic [DataWidth-1:0]   w_a;
   logic [DataWidth-1:0]   w_b;
   logic [NB+DataWidth-1:0] w_word;

   assign w_last_rdy = ~r_vl | bus.ready_i;

   generate
      if (NumStages == 2) begin : g_two
         logic                 r_v0;
         logic [1:0]           r_op;
         logic [1:0]           r_vew;
         logic [1:0]           r_rm;
         logic [DataWidth-1:0] r_a;
         logic [DataWidth-1:0] r_b;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_v0 <= 1'b0;
            end else if (w_ready) begin
               r_v0 <= bus.valid_i;
            end
         end

         always_ff @(posedge clk_i) begin
            if (bus.valid_i && w_ready) begin
               r_op  <= bus.op_i;
               r_vew <= bus.vew_i;
               r_rm  <= bus.vxrm_i;
               r_a   <= bus.operand_a_i;
               r_b   <= bus.operand_b_i;
            end
         end

         assign w_ready = ~r_v0 | w_last_rdy;
         assign w_in_v  = r_v0;
         assign w_op    = r_op;
         assign w_vew   = r_vew;
         assign w_rm    = r_rm;
         assign w_a     = r_a;
         assign w_b     = r_b;
      end else begin : g_one
         assign w_ready = w_last_rdy;
         assign w_in_v  = bus.valid_i;
         assign w_op    = bus.op_i;
         assign w_vew   = bus.vew_i;
         assign w_rm    = bus.vxrm_i;
         assign w_a     = bus.operand_a_i;
         assign w_b     = bus.operand_b_i;
      end
   endgenerate

   assign w_word = f_word(w_op, w_vew, w_rm, w_a, w_b);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vl  <= 1'b0;
         r_res <= '0;
         r_sat <= '0;
      end else if (w_last_rdy) begin
         r_vl <= w_in_v;
         if (w_in_v) begin
            r_res <= w_word[DataWidth-1:0];
            r_sat <= w_word[NB+DataWidth-1:DataWidth];
         end
      end
   end

   // A saturating handshake outranks a simultaneous clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vxsat <= 1'b0;
      end else if (r_vl && bus.ready_i && (|r_sat)) begin
         r_vxsat <= 1'b1;
      end else if (bus.vxsat_clr_i) begin
         r_vxsat <= 1'b0;
      end
   end

   assign bus.ready_o  = w_ready;
   assign bus.valid_o  = r_vl;
   assign bus.result_o = r_res;
   assign bus.sat_o    = r_sat;
   assign bus.vxsat_o  = r_vxsat;
endmodule

// File: tb/tb_fixed_p_scaling_shifter.sv
// Randomised and directed bench for fixed_p_scaling_shifter against an
// arithmetic reference model.
module tb_fixed_p_scaling_shifter;
   localparam int DW = 64;
   localparam int NS = 2;
   localparam int NB = DW / 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fixed_p_scaling_shifter_if #(.DataWidth(DW)) bus ();

   fixed_p_scaling_shifter #(.DataWidth(DW), .NumStages(NS)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_out   = 0;

   typedef struct packed {
      logic [DW-1:0] res;
      logic [NB-1:0] sat;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: rounding expressed through the discarded remainder.
   task automatic model(input logic [1:0] op, input logic [1:0] vew,
                        input logic [1:0] rm, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, output logic [DW-1:0] res,
                        output logic [NB-1:0] sat);
      int sew;
      int d;
      int h;
      logic [DW-1:0] ta;
      logic [DW-1:0] tb;
      logic [71:0] src;
      logic signed [71:0] one, mask, val, v, rem, half, r, sum, hi, lo;
      one = 1;
      sew = 8 << vew;
      res = '0;
      sat = '0;
      for (int e = 0; e < DW / sew; e++) begin
         mask = (one << sew) - one;
         ta = a >> (e * sew);
         tb = b >> (e * sew);
         d = int'(ta[5:0]) & (sew - 1);
         src = {8'd0, tb[63:0]} & mask;
         val = src;
         if (op[0] && src[sew-1]) val = val - (one << sew);
         v = val >>> d;
         rem = src & ((one << d) - one);
         half = (d == 0) ? 0 : (one << (d - 1));
         r = 0;
         if (d != 0) begin
            case (rm)
               2'd0: r = (rem >= half) ? 1 : 0;
               2'd1: r = ((rem > half) || (rem == half && v[0])) ? 1 : 0;
               2'd2: r = 0;
               default: r = ((rem != 0) && !v[0]) ? 1 : 0;
            endcase
         end
         sum = v + r;
         if (!op[1]) begin
            res |= DW'(sum & mask) << (e * sew);
         end else if (sew > 8) begin
            h = sew / 2;
            if (op[0]) begin
               hi = (one << (h - 1)) - one;
               lo = -(one << (h - 1));
            end else begin
               hi = (one << h) - one;
               lo = 0;
            end
            if (sum > hi || sum < lo) begin
               sum = (sum > hi) ? hi : lo;
               for (int k = 0; k < sew / 8; k++) sat[e*(sew/8)+k] = 1'b1;
            end
            res |= DW'(sum & ((one << h) - one)) << (e * sew);
         end
      end
   endtask

   // Compare process: sampled on the falling edge, mid-cycle.
   logic          mdl_vx = 1'b0;
   bit            armed = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_res;
   logic [NB-1:0] prev_sat;

   always @(negedge clk) begin
      exp_t          x;
      logic [DW-1:0] mr;
      logic [NB-1:0] ms;
      logic          hs_sat;
      hs_sat = 1'b0;
      if (armed) begin
         chk("vxsat", bus.vxsat_o, mdl_vx);
         if (prev_stall) begin
            chk("stall_valid", bus.valid_o, 1);
            chk("stall_res", bus.result_o, prev_res);
            chk("stall_sat", bus.sat_o, prev_sat);
         end
         if (bus.valid_o && bus.ready_i && !rst) begin
            n_out++;
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: got %0h expected none",
                        bus.result_o);
            end else begin
               x = q.pop_front();
               chk("out_res", bus.result_o, x.res);
               chk("out_sat", bus.sat_o, x.sat);
               hs_sat = |x.sat;
            end
         end
      end
      prev_stall = armed && !rst && bus.valid_o && !bus.ready_i;
      prev_res = bus.result_o;
      prev_sat = bus.sat_o;
      if (rst) begin
         q.delete();
         mdl_vx = 1'b0;
         armed = 1;
      end else if (armed) begin
         if (hs_sat) mdl_vx = 1'b1;
         else if (bus.vxsat_clr_i) mdl_vx = 1'b0;
         if (bus.valid_i && bus.ready_o) begin
            model(bus.op_i, bus.vew_i, bus.vxrm_i, bus.operand_a_i,
                  bus.operand_b_i, mr, ms);
            x.res = mr;
            x.sat = ms;
            q.push_back(x);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [1:0] vew,
                        input logic [1:0] rm, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
      bus.op_i = op;
      bus.vew_i = vew;
      bus.vxrm_i = rm;
      bus.operand_a_i = a;
      bus.operand_b_i = b;
   endtask

   task automatic one_word(input string nm, input logic [1:0] op,
                           input logic [1:0] vew, input logic [1:0] rm,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] er, input logic [NB-1:0] es);
      int cyc;
      bus.ready_i = 1'b1;
      chk({nm, "_ready"}, bus.ready_o, 1);
      bus.valid_i = 1'b1;
      drive(op, vew, rm, a, b);
      tick();
      bus.valid_i = 1'b0;
      cyc = 1;
      while (!bus.valid_o && cyc < 20) begin
         tick();
         cyc++;
      end
      chk({nm, "_lat"}, cyc, NS);
      chk({nm, "_res"}, bus.result_o, er);
      chk({nm, "_sat"}, bus.sat_o, es);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int drop_at;
      int out0;
      int wait_c;
      logic took;
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      bus.vxsat_clr_i = 1'b0;
      drive(2'd0, 2'd0, 2'd0, '0, '0);
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_ready", bus.ready_o, 1);
      chk("rst_res", bus.result_o, 0);
      chk("rst_sat", bus.sat_o, 0);
      chk("rst_vxsat", bus.vxsat_o, 0);

      one_word("ssrl_rnu", 2'd0, 2'd0, 2'd0, 64'h02020202,
               64'h090E0A0B, 64'h02040303, '0);
      one_word("ssrl_rne", 2'd0, 2'd0, 2'd1, 64'h02020202,
               64'h090E0A0B, 64'h02040203, '0);
      one_word("ssrl_rdn", 2'd0, 2'd0, 2'd2, 64'h02020202,
               64'h090E0A0B, 64'h02030202, '0);
      one_word("ssrl_rod", 2'd0, 2'd0, 2'd3, 64'h02020202,
               64'h090E0A0B, 64'h03030303, '0);
      one_word("ssra_d1", 2'd1, 2'd1, 2'd0, 64'h0001, 64'h8001,
               64'hC001, '0);
      one_word("ssra_d17", 2'd1, 2'd1, 2'd0, 64'h0011, 64'h8001,
               64'hC001, '0);
      one_word("ssra_d0", 2'd1, 2'd1, 2'd0, 64'h0000, 64'h8001,
               64'h8001, '0);
      one_word("nclip_u8", 2'd2, 2'd0, 2'd0, 64'h0, 64'hFFFF,
               64'h0, '0);
      one_word("nclip_f0", 2'd3, 2'd1, 2'd0, 64'h0004, 64'h00F0,
               64'h000F, '0);
      one_word("nclipu", 2'd2, 2'd1, 2'd2, 64'h0004, 64'h1234,
               64'h00FF, 8'h03);
      chk("nclipu_vxsat", bus.vxsat_o, 1);
      one_word("nclip_neg", 2'd3, 2'd1, 2'd0, 64'h0000, 64'h8000,
               64'h0080, 8'h03);

      // Reset with two words in flight.
      bus.ready_i = 1'b0;
      bus.valid_i = 1'b1;
      drive(2'd0, 2'd3, 2'd0, '0, 64'h1234_5678_9ABC_DEF0);
      tick();
      drive(2'd1, 2'd2, 2'd1, '0, 64'h0FED_CBA9_8765_4321);
      tick();
      bus.valid_i = 1'b0;
      chk("pre_rst_valid", bus.valid_o, 1);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", bus.valid_o, 0);
      chk("mid_rst_res", bus.result_o, 0);
      chk("mid_rst_vxsat", bus.vxsat_o, 0);
      chk("mid_rst_ready", bus.ready_o, 1);
      rst = 1'b0;
      bus.ready_i = 1'b1;
      tick();

      // Saturating handshake together with a clear: the set wins.
      bus.valid_i = 1'b1;
      drive(2'd2, 2'd1, 2'd2, 64'h0004, 64'h1234);
      tick();
      bus.valid_i = 1'b0;
      wait_c = 0;
      while (!bus.valid_o && wait_c < 20) begin
         tick();
         wait_c++;
      end
      bus.vxsat_clr_i = 1'b1;
      tick();
      chk("sticky_set_wins", bus.vxsat_o, 1);
      tick();
      chk("sticky_clear", bus.vxsat_o, 0);
      bus.vxsat_clr_i = 1'b0;
      tick();

      // Backpressure: five words, consumer stalls on cycles 3..6.
      acc = 0;
      drop_at = -1;
      out0 = n_out;
      for (int c = 0; c < 30; c++) begin
         bus.ready_i = !(c >= 3 && c <= 6);
         bus.valid_i = (acc < 5);
         drive(2'd0, 2'd1, 2'd0, '0, 64'h1111 * (acc + 1));
         #1;
         took = bus.valid_i && bus.ready_o;
         if (!bus.ready_o && drop_at < 0) drop_at = acc;
         tick();
         if (took) acc++;
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      tick();
      chk("bp_accept_before_drop", drop_at, 3);
      chk("bp_outputs", n_out - out0, 5);
      chk("bp_queue_empty", q.size(), 0);

      // Randomised traffic with stalls, gaps and clears.
      took = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (took || !bus.valid_i) begin
            bus.valid_i = ($urandom_range(3) != 0);
            drive(2'($urandom), 2'($urandom), 2'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom});
         end
         bus.ready_i = ($urandom_range(3) != 0);
         bus.vxsat_clr_i = ($urandom_range(15) == 0);
         @(negedge clk);
         took = bus.valid_i && bus.ready_o;
         tick();
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      bus.vxsat_clr_i = 1'b0;
      wait_c = 0;
      while (q.size() != 0 && wait_c < 50) begin
         tick();
         wait_c++;
      end
      tick();
      chk("drain_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
